ex_muldiv: RTL and testbench
============================

Name: ex_muldiv

Overview:
- Parametrised multi-cycle multiply / divide / multiply-accumulate unit for the execute stage.
- Takes over HI/LO-producing arithmetic from the single-cycle ALU: MULT/MULTU, DIV/DIVU, MADD/MADDU, MSUB/MSUBU.
- Stalls the pipeline while iterating, then delivers one HI/LO write to the ex/mem path.
- HI/LO accumulator inputs arrive already forwarded (mem > wb > register file priority, resolved upstream).

Parameters:
- WIDTH, 32, operand width and HI/LO register width; even, 8..64.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low; `ResetEnable is 1'b0.
- start  in  1  op valid in this cycle; sampled only in IDLE.
- op  in  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MADD 5=MADDU 6=MSUB 7=MSUBU.
- opa  in  WIDTH  multiplicand / dividend (rs).
- opb  in  WIDTH  multiplier / divisor (rt).
- hi_in  in  WIDTH  forwarded HI, sampled at start.
- lo_in  in  WIDTH  forwarded LO, sampled at start.
- annul  in  1  flush; abandons the current operation.
- stall_req  out  1  pipeline hold request.
- done  out  1  one-cycle result strobe.
- whilo_out  out  1  HI/LO write enable; equals done.
- hi_out  out  WIDTH  result HI.
- lo_out  out  WIDTH  result LO.
- div_by_zero  out  1  valid with done; divisor was zero.

Behaviour:
- States: IDLE, MUL, DIV, ACC, DONE.
- Reset, asynchronous: state=IDLE. All outputs and internal registers 0.
- Start (cycle 0): IDLE with start=1 and annul=0 latches the following:
  - operand magnitudes; signed ops take abs values, unsigned ops take raw values;
  - result sign and remainder sign: remainder sign follows the dividend;
  - hi_in/lo_in and op;
  - iteration counter = WIDTH.
  - Next state is MUL (ops 0,1,4-7) or DIV (ops 2,3).
- Divide by zero: DIV/DIVU with opb=0 goes straight to DONE at cycle 1, with LO={WIDTH{1}}, HI=opa, div_by_zero=1.
- MUL: shift-add, one multiplier bit per cycle over cycles 1..WIDTH, into a 2*WIDTH product register. The final sign fix (two's-complement negate when the signs differ) is applied in cycle WIDTH.
- DIV: restoring, one quotient bit per cycle over cycles 1..WIDTH.
  - Sign fix: quotient negated if signs differ; remainder negated if dividend negative.
  - Results truncate to WIDTH. MIN/-1 gives LO=MIN, HI=0.
- ACC (MADD/MSUB only, cycle WIDTH+1): {hi,lo} = {hi_in,lo_in} +/- product, modulo 2^(2*WIDTH).
- Latency from the start cycle to the DONE cycle:
  - MULT/DIV: WIDTH+1 cycles.
  - MADD/MSUB: WIDTH+2 cycles.
  - Divide by zero: 1 cycle.
- DONE: done=whilo_out=1 for exactly one cycle.
  - hi_out/lo_out are registered and valid in that cycle; 0 in all other cycles.
  - DIV/DIVU: LO=quotient, HI=remainder. Multiply ops: HI=upper half, LO=lower half.
  - Next state is IDLE. A start in the DONE cycle is ignored; a back-to-back op must re-present start in IDLE.
- stall_req:
  - combinationally 1 in IDLE when start=1 and annul=0;
  - 1 in MUL, DIV and ACC;
  - 0 in DONE and otherwise, so the instruction retires with the result.
- start outside IDLE is ignored and leaves the operation undisturbed.
- annul:
  - In any non-IDLE state: next state IDLE. No done is issued for the annulled op, and no HI/LO write occurs.
  - annul in DONE suppresses done and whilo_out that cycle.
  - annul together with start in IDLE means the start is not accepted.
- Reset asserted mid-operation aborts immediately. No done is issued.

Decomposition:
- defines.v gains the following constants:
  - the MULDIV op encodings (MULT..MSUBU);
  - state encodings IDLE/MUL/DIV/ACC/DONE;
  - `ResetEnable=1'b0.
- One sub-module: div_core, the restoring-division datapath. It takes start/annul and outputs quotient, remainder and ready; it is parametrised by WIDTH.
- Multiply, accumulate, sign handling and the FSM stay in ex_muldiv.

Test Plan:
- WIDTH=32, MULT opa=FFFFFFFF opb=00000002 -> done at cycle 33, HI=FFFFFFFF LO=FFFFFFFE; stall_req high cycles 0..32, low at cycle 33.
- DIVU 100/7 -> LO=0000000E HI=00000002. DIV -7/2 -> LO=FFFFFFFD HI=FFFFFFFF. DIV 80000000/FFFFFFFF -> LO=80000000 HI=0.
- MADDU hi_in=0 lo_in=FFFFFFFF, 1*1 -> done at cycle 34, HI=00000001 LO=00000000. MSUB hi_in=lo_in=0, 2*3 -> HI=FFFFFFFF LO=FFFFFFFA.
- DIV opa=12345678 opb=0 -> done at cycle 1, div_by_zero=1, LO=FFFFFFFF HI=12345678.
- MULT started, annul at cycle 10 -> no done, state IDLE at cycle 11. New DIVU 9/3 started at cycle 11 -> LO=3 HI=0 at cycle 44.
- Reset pulled low at cycle 5 of a DIV -> all outputs 0 at once, no done after release. A start held during the busy cycles is ignored.

Source files
------------

// File: rtl/ex_muldiv_pkg.sv
// Shared encodings and op-decode helpers for the multi-cycle mul/div unit.
package ex_muldiv_pkg;

  // Reset is asserted at this level
  localparam logic RESET_ENABLE = 1'b0;

  // MULDIV op encodings
  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MADD  = 3'd4;
  localparam logic [2:0] OP_MADDU = 3'd5;
  localparam logic [2:0] OP_MSUB  = 3'd6;
  localparam logic [2:0] OP_MSUBU = 3'd7;

  // FSM state encodings
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_MUL  = 3'd1;
  localparam logic [2:0] S_DIV  = 3'd2;
  localparam logic [2:0] S_ACC  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  function automatic logic op_is_div(input logic [2:0] code);
    return (code == OP_DIV) || (code == OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input logic [2:0] code);
    return (code == OP_MULT) || (code == OP_DIV) || (code == OP_MADD) || (code == OP_MSUB);
  endfunction

  function automatic logic op_is_acc(input logic [2:0] code);
    return (code == OP_MADD) || (code == OP_MADDU) || (code == OP_MSUB) || (code == OP_MSUBU);
  endfunction

  function automatic logic op_is_sub(input logic [2:0] code);
    return (code == OP_MSUB) || (code == OP_MSUBU);
  endfunction

endpackage

// File: rtl/ex_muldiv_div_core.sv
// Restoring unsigned divider, one quotient bit per cycle.
// Quotient/remainder outputs are the values produced by the current step,
// so they hold the final result in the cycle where o_ready_c is high.
module ex_muldiv_div_core
  import ex_muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_annul,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_quotient_c,
  output logic [WIDTH-1:0] o_remainder_c,
  output logic             o_ready_c
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic             r_busy;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_d;
  logic [WIDTH:0]   w_partial;
  logic [WIDTH:0]   w_diff;
  logic             w_fits;

  // One trial subtraction: shift in the next dividend bit, keep the difference if it fits
  always_comb begin
    w_partial     = {r_rem, r_q[WIDTH-1]};
    w_diff        = w_partial - {1'b0, r_d};
    w_fits        = !w_diff[WIDTH];
    o_remainder_c = w_fits ? w_diff[WIDTH-1:0] : w_partial[WIDTH-1:0];
    o_quotient_c  = {r_q[WIDTH-2:0], w_fits};
    o_ready_c     = r_busy && (r_cnt == CW'(1));
  end

  // Iteration registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (i_rst_n == RESET_ENABLE) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
      r_q    <= '0;
      r_rem  <= '0;
      r_d    <= '0;
    end else if (i_annul) begin
      r_busy <= 1'b0;
    end else if (i_start) begin
      r_busy <= 1'b1;
      r_cnt  <= CW'(WIDTH);
      r_q    <= i_dividend;
      r_d    <= i_divisor;
      r_rem  <= '0;
    end else if (r_busy) begin
      r_q   <= o_quotient_c;
      r_rem <= o_remainder_c;
      r_cnt <= r_cnt - CW'(1);
      if (o_ready_c) r_busy <= 1'b0;
    end
  end

endmodule

// File: rtl/ex_muldiv.sv
// Multi-cycle MULT/DIV/MADD/MSUB unit producing one HI/LO write per op.
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic [WIDTH-1:0] hi_in,
  input  logic [WIDTH-1:0] lo_in,
  input  logic             annul,
  output logic             stall_req,
  output logic             done,
  output logic             whilo_out,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             div_by_zero
);

  localparam int unsigned DW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic [2:0]       r_state;
  logic [2:0]       w_state_next;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_mag_a;
  logic [WIDTH-1:0] r_hi_acc;
  logic [WIDTH-1:0] r_lo_acc;
  logic [WIDTH-1:0] r_hi_out;
  logic [WIDTH-1:0] r_lo_out;
  logic [DW-1:0]    r_prod;
  logic [CW-1:0]    r_cnt;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_dbz;

  logic             w_accept;
  logic             w_signed;
  logic             w_last;
  logic             w_div_start;
  logic             w_div_ready;
  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;
  logic [WIDTH-1:0] w_quot;
  logic [WIDTH-1:0] w_rem;
  logic [WIDTH:0]   w_sum;
  logic [DW-1:0]    w_step;
  logic [DW-1:0]    w_prod_fix;
  logic [DW-1:0]    w_acc;
  logic [WIDTH-1:0] w_hi_res;
  logic [WIDTH-1:0] w_lo_res;

  // Operand magnitudes, shift-add step and accumulate
  always_comb begin
    w_accept    = (r_state == S_IDLE) && start && !annul;
    w_signed    = op_is_signed(op);
    w_mag_a     = (w_signed && opa[WIDTH-1]) ? -opa : opa;
    w_mag_b     = (w_signed && opb[WIDTH-1]) ? -opb : opb;
    w_div_start = w_accept && op_is_div(op) && (opb != '0);
    w_last      = (r_cnt == CW'(1));
    w_sum       = {1'b0, r_prod[DW-1:WIDTH]} + (r_prod[0] ? {1'b0, r_mag_a} : '0);
    w_step      = {w_sum, r_prod[WIDTH-1:1]};
    w_prod_fix  = r_neg_q ? -w_step : w_step;
    w_acc       = op_is_sub(r_op) ? ({r_hi_acc, r_lo_acc} - r_prod)
                                  : ({r_hi_acc, r_lo_acc} + r_prod);
  end

  ex_muldiv_div_core #(.WIDTH(WIDTH)) u_div_core (
    .i_clk         (clock),
    .i_rst_n       (reset),
    .i_start       (w_div_start),
    .i_annul       (annul),
    .i_dividend    (w_mag_a),
    .i_divisor     (w_mag_b),
    .o_quotient_c  (w_quot),
    .o_remainder_c (w_rem),
    .o_ready_c     (w_div_ready)
  );

  // Result selected by the state that hands over to DONE
  always_comb begin
    w_hi_res = '0;
    w_lo_res = '0;
    case (r_state)
      S_IDLE: begin
        w_hi_res = opa;
        w_lo_res = '1;
      end
      S_MUL: begin
        w_hi_res = w_prod_fix[DW-1:WIDTH];
        w_lo_res = w_prod_fix[WIDTH-1:0];
      end
      S_DIV: begin
        w_hi_res = r_neg_r ? -w_rem : w_rem;
        w_lo_res = r_neg_q ? -w_quot : w_quot;
      end
      S_ACC: begin
        w_hi_res = w_acc[DW-1:WIDTH];
        w_lo_res = w_acc[WIDTH-1:0];
      end
      default: ;
    endcase
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (op_is_div(op)) w_state_next = (opb == '0) ? S_DONE : S_DIV;
          else               w_state_next = S_MUL;
        end
      end
      S_MUL: begin
        if (annul)       w_state_next = S_IDLE;
        else if (w_last) w_state_next = op_is_acc(r_op) ? S_ACC : S_DONE;
      end
      S_DIV: begin
        if (annul)            w_state_next = S_IDLE;
        else if (w_div_ready) w_state_next = S_DONE;
      end
      S_ACC:   w_state_next = annul ? S_IDLE : S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (reset == RESET_ENABLE) r_state <= S_IDLE;
    else                       r_state <= w_state_next;
  end

  // Operand latch, multiplier iteration and registered result
  always_ff @(posedge clock or negedge reset) begin
    if (reset == RESET_ENABLE) begin
      r_op     <= '0;
      r_mag_a  <= '0;
      r_hi_acc <= '0;
      r_lo_acc <= '0;
      r_prod   <= '0;
      r_cnt    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_hi_out <= '0;
      r_lo_out <= '0;
      r_dbz    <= 1'b0;
    end else begin
      r_hi_out <= '0;
      r_lo_out <= '0;
      r_dbz    <= 1'b0;
      if (w_state_next == S_DONE) begin
        r_hi_out <= w_hi_res;
        r_lo_out <= w_lo_res;
        r_dbz    <= (r_state == S_IDLE);
      end
      if (w_accept) begin
        r_op     <= op;
        r_mag_a  <= w_mag_a;
        r_prod   <= {{WIDTH{1'b0}}, w_mag_b};
        r_hi_acc <= hi_in;
        r_lo_acc <= lo_in;
        r_neg_q  <= w_signed && (opa[WIDTH-1] ^ opb[WIDTH-1]);
        r_neg_r  <= w_signed && opa[WIDTH-1];
        r_cnt    <= CW'(WIDTH);
      end else if (r_state == S_MUL) begin
        r_prod <= w_last ? w_prod_fix : w_step;
        r_cnt  <= r_cnt - CW'(1);
      end
    end
  end

  // The strobe is killed by a same-cycle flush so no HI/LO write escapes
  assign stall_req   = w_accept || (r_state == S_MUL) || (r_state == S_DIV) || (r_state == S_ACC);
  assign done        = (r_state == S_DONE) && !annul;
  assign whilo_out   = done;
  assign hi_out      = r_hi_out;
  assign lo_out      = r_lo_out;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv (WIDTH=32) against an arithmetic reference model.
module tb_ex_muldiv;

  localparam int unsigned W = 32;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic [2:0]    op;
  logic [W-1:0]  opa;
  logic [W-1:0]  opb;
  logic [W-1:0]  hi_in;
  logic [W-1:0]  lo_in;
  logic          annul;
  logic          stall_req;
  logic          done;
  logic          whilo_out;
  logic [W-1:0]  hi_out;
  logic [W-1:0]  lo_out;
  logic          div_by_zero;

  int n_cmp = 0;
  int n_err = 0;

  ex_muldiv #(.WIDTH(W)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .opa         (opa),
    .opb         (opb),
    .hi_in       (hi_in),
    .lo_in       (lo_in),
    .annul       (annul),
    .stall_req   (stall_req),
    .done        (done),
    .whilo_out   (whilo_out),
    .hi_out      (hi_out),
    .lo_out      (lo_out),
    .div_by_zero (div_by_zero)
  );

  always #5 clock = ~clock;

  // Reference: plain 64-bit arithmetic on the architectural definition of each op
  function automatic void model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] h, input logic [31:0] l,
                                output logic [31:0] eh, output logic [31:0] el,
                                output logic ez, output int lat);
    longint sa, sb, q, r;
    logic [63:0] prod, acc;
    bit sgn;
    sgn = (o[0] == 1'b0);
    if (sgn) begin sa = $signed(a); sb = $signed(b); end
    else     begin sa = {32'd0, a}; sb = {32'd0, b}; end
    ez = 1'b0;
    if (o == 3'd2 || o == 3'd3) begin
      if (b == 32'd0) begin
        ez = 1'b1; eh = a; el = 32'hFFFF_FFFF; lat = 1;
      end else begin
        q = sa / sb; r = sa % sb;
        el = q[31:0]; eh = r[31:0]; lat = W + 1;
      end
    end else begin
      prod = sa * sb;
      if (o >= 3'd4) begin
        acc = (o >= 3'd6) ? ({h, l} - prod) : ({h, l} + prod);
        lat = W + 2;
      end else begin
        acc = prod;
        lat = W + 1;
      end
      eh = acc[63:32]; el = acc[31:0];
    end
  endfunction

  // Issue one op from IDLE (called at a negedge) and check timing, strobe and result
  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] h, input logic [31:0] l,
                        input logic [31:0] eh, input logic [31:0] el, input logic ez,
                        input int elat, input bit hold, input bit start_in_done);
    int lat;
    bit seen;
    bit quiet_ok;
    op = o; opa = a; opb = b; hi_in = h; lo_in = l; start = 1'b1;
    #1;
    n_cmp++;
    if (stall_req !== 1'b1) begin
      n_err++; $display("FAIL %s stall_c0: got %b expected 1", name, stall_req);
    end
    lat = 0; seen = 0; quiet_ok = 1;
    for (int n = 1; n <= 100 && !seen; n++) begin
      @(negedge clock);
      if (done === 1'b1) begin
        seen = 1; lat = n;
      end else if (stall_req !== 1'b1 || whilo_out !== 1'b0 || hi_out !== '0 || lo_out !== '0) begin
        quiet_ok = 0;
      end
      if (!seen) begin
        if (hold) begin
          op = 3'($urandom_range(0, 7)); opa = $urandom; opb = $urandom;
          hi_in = $urandom; lo_in = $urandom;
        end else begin
          start = 1'b0;
        end
      end
    end
    if (start_in_done) begin
      op = 3'd1; opa = $urandom; opb = $urandom; start = 1'b1;
    end else begin
      start = 1'b0;
    end
    #1;
    n_cmp++;
    if (!seen) begin
      n_err++; $display("FAIL %s latency: no done within 100 cycles, expected %0d", name, elat);
    end else if (lat != elat) begin
      n_err++; $display("FAIL %s latency: got %0d expected %0d", name, lat, elat);
    end
    n_cmp++;
    if (hi_out !== eh) begin
      n_err++; $display("FAIL %s hi_out: got %h expected %h", name, hi_out, eh);
    end
    n_cmp++;
    if (lo_out !== el) begin
      n_err++; $display("FAIL %s lo_out: got %h expected %h", name, lo_out, el);
    end
    n_cmp++;
    if (div_by_zero !== ez || whilo_out !== 1'b1 || stall_req !== 1'b0) begin
      n_err++; $display("FAIL %s done_flags: got dbz=%b whilo=%b stall=%b expected dbz=%b whilo=1 stall=0",
                        name, div_by_zero, whilo_out, stall_req, ez);
    end
    n_cmp++;
    if (!quiet_ok) begin
      n_err++; $display("FAIL %s busy_cycles: got bad stall/whilo/result while busy expected stall=1 outputs 0", name);
    end
    @(negedge clock);
    start = 1'b0;
    #1;
    n_cmp++;
    if (done !== 1'b0 || stall_req !== 1'b0 || hi_out !== '0 || lo_out !== '0 || div_by_zero !== 1'b0) begin
      n_err++; $display("FAIL %s after_done: got done=%b stall=%b hi=%h lo=%h dbz=%b expected all 0",
                        name, done, stall_req, hi_out, lo_out, div_by_zero);
    end
  endtask

  // Checked variant: expected values come from the reference model
  task automatic run_model(input string name, input logic [2:0] o, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] h, input logic [31:0] l,
                           input bit hold, input bit start_in_done);
    logic [31:0] eh, el;
    logic ez;
    int lat;
    model(o, a, b, h, l, eh, el, ez, lat);
    run_op(name, o, a, b, h, l, eh, el, ez, lat, hold, start_in_done);
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; annul = 1'b0; op = '0;
    opa = '0; opb = '0; hi_in = '0; lo_in = '0;
    repeat (3) @(negedge clock);
    n_cmp++;
    if (stall_req !== 1'b0 || done !== 1'b0 || whilo_out !== 1'b0 || hi_out !== '0 ||
        lo_out !== '0 || div_by_zero !== 1'b0) begin
      n_err++; $display("FAIL reset_state: got stall=%b done=%b whilo=%b hi=%h lo=%h dbz=%b expected all 0",
                        stall_req, done, whilo_out, hi_out, lo_out, div_by_zero);
    end
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_directed();
    run_op("mult_m1x2", 3'd0, 32'hFFFF_FFFF, 32'h2, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, 33, 0, 0);
    run_op("divu_100_7", 3'd3, 32'd100, 32'd7, 0, 0, 32'h2, 32'hE, 0, 33, 0, 0);
    run_op("div_m7_2", 3'd2, 32'hFFFF_FFF9, 32'd2, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 33, 0, 0);
    run_op("div_min_m1", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 32'h0, 32'h8000_0000, 0, 33, 0, 0);
    run_op("maddu_carry", 3'd5, 32'd1, 32'd1, 32'h0, 32'hFFFF_FFFF, 32'h1, 32'h0, 0, 34, 0, 0);
    run_op("msub_2x3", 3'd6, 32'd2, 32'd3, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 0, 34, 0, 0);
    run_op("div_by_zero", 3'd2, 32'h1234_5678, 32'h0, 0, 0, 32'h1234_5678, 32'hFFFF_FFFF, 1, 1, 0, 0);
    run_op("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 32'hFFFF_FFFE, 32'h1, 0, 33, 0, 0);
  endtask

  task automatic test_annul();
    bit early_done;
    early_done = 0;
    op = 3'd0; opa = $urandom; opb = $urandom; start = 1'b1;
    for (int n = 1; n <= 11; n++) begin
      @(negedge clock);
      if (done !== 1'b0) early_done = 1;
      start = 1'b0;
      annul = (n == 10);
    end
    #1;
    n_cmp++;
    if (early_done || stall_req !== 1'b0 || done !== 1'b0) begin
      n_err++; $display("FAIL annul_mul: got early_done=%b stall=%b done=%b expected 0 0 0",
                        early_done, stall_req, done);
    end
    run_op("divu_after_annul", 3'd3, 32'd9, 32'd3, 0, 0, 32'h0, 32'h3, 0, 33, 0, 0);
  endtask

  task automatic test_annul_in_done();
    op = 3'd3; opa = 32'hABCD; opb = '0; start = 1'b1;
    @(negedge clock);
    start = 1'b0; annul = 1'b1;
    #1;
    n_cmp++;
    if (done !== 1'b0 || whilo_out !== 1'b0) begin
      n_err++; $display("FAIL annul_done: got done=%b whilo=%b expected 0 0", done, whilo_out);
    end
    @(negedge clock);
    annul = 1'b0;
    #1;
    n_cmp++;
    if (done !== 1'b0 || stall_req !== 1'b0) begin
      n_err++; $display("FAIL annul_done_after: got done=%b stall=%b expected 0 0", done, stall_req);
    end
  endtask

  task automatic test_annul_with_start();
    op = 3'd1; opa = 32'd5; opb = 32'd6; start = 1'b1; annul = 1'b1;
    #1;
    n_cmp++;
    if (stall_req !== 1'b0) begin
      n_err++; $display("FAIL annul_start_stall: got %b expected 0", stall_req);
    end
    @(negedge clock);
    start = 1'b0; annul = 1'b0;
    #1;
    n_cmp++;
    if (stall_req !== 1'b0) begin
      n_err++; $display("FAIL annul_start_idle: got stall=%b expected 0", stall_req);
    end
  endtask

  task automatic test_reset_mid();
    bit bad;
    bad = 0;
    op = 3'd2; opa = $urandom; opb = 32'h0000_1234; start = 1'b1;
    for (int n = 1; n <= 5; n++) begin
      @(negedge clock);
      start = 1'b0;
    end
    reset = 1'b0;
    #1;
    n_cmp++;
    if (stall_req !== 1'b0 || done !== 1'b0 || whilo_out !== 1'b0 || hi_out !== '0 ||
        lo_out !== '0 || div_by_zero !== 1'b0) begin
      n_err++; $display("FAIL reset_mid_div: got stall=%b done=%b hi=%h lo=%h expected all 0",
                        stall_req, done, hi_out, lo_out);
    end
    repeat (2) @(negedge clock);
    reset = 1'b1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clock);
      if (done !== 1'b0 || stall_req !== 1'b0) bad = 1;
    end
    n_cmp++;
    if (bad) begin
      n_err++; $display("FAIL reset_mid_after: got done/stall activity after release expected none");
    end
  endtask

  task automatic test_hold_start();
    run_model("hold_madd", 3'd4, $urandom, $urandom, $urandom, $urandom, 1, 0);
    run_model("hold_div", 3'd2, $urandom, 32'hFFFF_FFF3, 0, 0, 1, 0);
  endtask

  task automatic test_back_to_back();
    run_model("b2b_first", 3'd1, $urandom, $urandom, 0, 0, 0, 1);
    run_model("b2b_second", 3'd7, $urandom, $urandom, $urandom, $urandom, 0, 0);
  endtask

  task automatic test_random();
    logic [2:0] o;
    logic [31:0] a, b;
    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      if (i % 8 == 3) b = 32'h0;
      if (i % 8 == 5) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      if (i % 8 == 6) b = 32'($urandom_range(1, 15));
      run_model("random", o, a, b, $urandom, $urandom, 0, 0);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_annul();
    test_annul_in_done();
    test_annul_with_start();
    test_reset_mid();
    test_hold_start();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
